// File: rtl/bridge_data_loader.sv
`default_nettype none
// ============================================================================
//  Module      : bridge_data_loader
//  Description : APF bridge write path. Buffers 32-bit bridge writes in a small
//                FIFO and serializes each into OUTPUT_WORD_SIZE-byte memory writes.
//                Optional DATA_LOADER_ACK_EN adds a write_ack handshake input.
//  Revision    : 1.0 - initial release
// ============================================================================
module bridge_data_loader #(
    parameter int         OUTPUT_WORD_SIZE      = 2,
    parameter logic [3:0] ADDRESS_MASK_UPPER_4  = 4'h0,
    parameter int         FIFO_DEPTH            = 4,
    parameter int         WRITE_MEM_CLOCK_DELAY = 4
) (
    input  logic                          clk_74a,
    input  logic                          reset_n,
    input  logic                          bridge_wr,
    input  logic                          bridge_endian_little,
    input  logic [31:0]                   bridge_addr,
    input  logic [31:0]                   bridge_wr_data,
`ifdef DATA_LOADER_ACK_EN
    input  logic                          write_ack,
`endif
    output logic                          write_en,
    output logic [27:0]                   write_addr,
    output logic [8*OUTPUT_WORD_SIZE-1:0] write_data,
    output logic                          busy,
    output logic                          overflow
);

    localparam int c_DW     = 8 * OUTPUT_WORD_SIZE;
    localparam int c_CHUNKS = 4 / OUTPUT_WORD_SIZE;
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_EW     = 28 + 32 + 1;
    localparam int c_CW     = (WRITE_MEM_CLOCK_DELAY > 1) ? $clog2(WRITE_MEM_CLOCK_DELAY) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } t_state;

    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]   r_wptr;
    logic [c_AW:0]   r_rptr;
    logic            r_overflow;

    t_state          r_state;
    logic [27:0]     r_cur_addr;
    logic [31:0]     r_cur_data;
    logic            r_cur_le;
    logic [1:0]      r_chunk;
    logic [c_CW-1:0] r_wait;
    logic            r_write_en;
    logic [27:0]     r_write_addr;
    logic [c_DW-1:0] r_write_data;

    logic            w_empty;
    logic            w_full;
    logic            w_hit;
    logic            w_pop;
    logic            w_push;
    logic [c_EW-1:0] w_head;
    logic [31:0]     w_swap;
    logic [5:0]      w_shamt;
    logic [c_DW-1:0] w_chunk_data;
    logic [27:0]     w_chunk_addr;
    logic            w_last;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_hit   = bridge_wr && (bridge_addr[31:28] == ADDRESS_MASK_UPPER_4);
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    // A full FIFO still accepts when the serializer drains an entry in the same cycle.
    assign w_push  = w_hit && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr[c_AW-1:0]];

    // Big-endian words are byte-reversed, then consumed from the top down.
    assign w_swap       = {r_cur_data[7:0], r_cur_data[15:8], r_cur_data[23:16], r_cur_data[31:24]};
    assign w_shamt      = r_cur_le ? 6'(c_DW * r_chunk) : 6'(32 - c_DW - c_DW * r_chunk);
    assign w_chunk_data = c_DW'((r_cur_le ? r_cur_data : w_swap) >> w_shamt);
    assign w_chunk_addr = r_cur_addr + (28'(OUTPUT_WORD_SIZE) * 28'(r_chunk));
    assign w_last       = (r_chunk == 2'(c_CHUNKS - 1));

    always_ff @(posedge clk_74a) begin
        if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= {bridge_addr[27:0], bridge_wr_data, bridge_endian_little};
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + {{c_AW{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rptr <= r_rptr + {{c_AW{1'b0}}, 1'b1};
            end
            if (w_hit && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cur_addr   <= '0;
            r_cur_data   <= '0;
            r_cur_le     <= 1'b0;
            r_chunk      <= '0;
            r_wait       <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_cur_addr <= w_head[60:33];
                        r_cur_data <= w_head[32:1];
                        r_cur_le   <= w_head[0];
                        r_chunk    <= '0;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_write_en   <= 1'b1;
                    r_write_addr <= w_chunk_addr;
                    r_write_data <= w_chunk_data;
                    r_wait       <= '0;
`ifdef DATA_LOADER_ACK_EN
                    r_state      <= S_HOLD;
`else
                    r_state      <= S_WAIT;
`endif
                end
`ifdef DATA_LOADER_ACK_EN
                S_HOLD: begin
                    if (write_ack) begin
                        r_write_en <= 1'b0;
                        r_state    <= S_WAIT;
                    end
                end
`endif
                S_WAIT: begin
                    r_write_en <= 1'b0;
                    if (r_wait == c_CW'(WRITE_MEM_CLOCK_DELAY - 1)) begin
                        if (w_last) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_chunk <= r_chunk + 2'd1;
                            r_state <= S_WRITE;
                        end
                    end else begin
                        r_wait <= r_wait + {{(c_CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_write_en <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign write_en   = r_write_en;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign busy       = !w_empty || (r_state != S_IDLE);
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bridge_data_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bridge_data_loader
//  Description : Directed self-checking bench; 16-bit (a) and 8-bit (b) instances
//                share one bridge input stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bridge_data_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr = 1'b0;
    logic        le = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;

    logic        a_en, a_busy, a_ovf;
    logic [27:0] a_addr;
    logic [15:0] a_data;
    logic        b_en, b_busy, b_ovf;
    logic [27:0] b_addr;
    logic [7:0]  b_data;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int kk      = 0;
    int fall_a  = -1;
    logic saw_busy = 1'b0;

    logic [43:0] q_a[$];
    int          c_a[$];
    logic [35:0] q_b[$];

    bridge_data_loader #(.OUTPUT_WORD_SIZE(2)) dut_a (
        .clk_74a(clk), .reset_n(reset_n), .bridge_wr(wr), .bridge_endian_little(le),
        .bridge_addr(addr), .bridge_wr_data(data),
        .write_en(a_en), .write_addr(a_addr), .write_data(a_data),
        .busy(a_busy), .overflow(a_ovf)
    );

    bridge_data_loader #(.OUTPUT_WORD_SIZE(1)) dut_b (
        .clk_74a(clk), .reset_n(reset_n), .bridge_wr(wr), .bridge_endian_little(le),
        .bridge_addr(addr), .bridge_wr_data(data),
        .write_en(b_en), .write_addr(b_addr), .write_data(b_data),
        .busy(b_busy), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_en) begin
            q_a.push_back({a_addr, a_data});
            c_a.push_back(cyc);
        end
        if (b_en) q_b.push_back({b_addr, b_data});
        if (a_busy || b_busy) saw_busy = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] qa(input int i);
        if (i < q_a.size()) return 64'(q_a[i]);
        return '1;
    endfunction

    function automatic logic [63:0] qb(input int i);
        if (i < q_b.size()) return 64'(q_b[i]);
        return '1;
    endfunction

    function automatic int ca(input int i);
        if (i < c_a.size()) return c_a[i];
        return -1000;
    endfunction

    task automatic clear_q();
        q_a.delete();
        c_a.delete();
        q_b.delete();
        fall_a = -1;
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic l);
        @(negedge clk);
        wr = 1'b1; addr = a; data = d; le = l;
        kk = cyc + 1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        while (n < max) begin
            @(negedge clk);
            if (!a_busy && fall_a < 0) fall_a = cyc;
            if (!a_busy && !b_busy) break;
            n++;
        end
        if (n >= max) check("idle_timeout", 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] e;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_en",   a_en,   0);
        check("rst_addr", a_addr, 0);
        check("rst_data", a_data, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ovf",  a_ovf,  0);
        check("rst_b_en", b_en,   0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Big-endian word, 16-bit and 8-bit outputs
        clear_q();
        do_wr(32'h0000_000C, 32'hDDCC_BBAA, 1'b0);
        wait_idle(300);
        check("t1_cnt",  q_a.size(), 2);
        check("t1_w0",   qa(0), {28'hC, 16'hAABB});
        check("t1_w1",   qa(1), {28'hE, 16'hCCDD});
        check("t1_lat",  ca(0), kk + 2);
        check("t1_gap",  ca(1) - ca(0), 5);
        check("t1_busy", fall_a, ca(1) + 4);
        check("t1b_cnt", q_b.size(), 4);
        e = 32'hAABB_CCDD;
        for (int i = 0; i < 4; i++) check("t1b_w", qb(i), {28'(28'hC + i), e[31-8*i -: 8]});

        // Little-endian word
        clear_q();
        do_wr(32'h0000_0124, 32'h1122_3344, 1'b1);
        wait_idle(300);
        check("t2_cnt", q_a.size(), 2);
        check("t2_w0",  qa(0), {28'h124, 16'h3344});
        check("t2_w1",  qa(1), {28'h126, 16'h1122});
        e = 32'h1122_3344;
        for (int i = 0; i < 4; i++) check("t2b_w", qb(i), {28'(28'h124 + i), e[8*i +: 8]});

        // Byte-wide big-endian at address 0
        clear_q();
        do_wr(32'h0000_0000, 32'hDDCC_BBAA, 1'b0);
        wait_idle(300);
        check("t3b_cnt", q_b.size(), 4);
        e = 32'hAABB_CCDD;
        for (int i = 0; i < 4; i++) check("t3b_w", qb(i), {28'(i), e[31-8*i -: 8]});

        // Address outside the window is ignored
        clear_q();
        saw_busy = 1'b0;
        do_wr(32'h1000_0000, 32'h1234_5678, 1'b1);
        repeat (20) @(negedge clk);
        check("t4_cnt_a", q_a.size(), 0);
        check("t4_cnt_b", q_b.size(), 0);
        check("t4_busy",  saw_busy, 0);
        check("t4_ovf",   a_ovf, 0);

        // 28-bit address wrap between chunks
        clear_q();
        do_wr(32'h0FFF_FFFE, 32'h0102_0304, 1'b0);
        wait_idle(300);
        check("wrap_w0", qa(0), {28'hFFF_FFFE, 16'h0403});
        check("wrap_w1", qa(1), {28'h000_0000, 16'h0201});
        check("wrap_b2", qb(2), {28'h000_0000, 8'h02});

        // Back-to-back burst: FIFO_DEPTH+1 survive, the last is dropped
        clear_q();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            wr = 1'b1; le = 1'b1;
            addr = 32'h100 + 32'(4 * i);
            data = {16'(16'h1000 + i), 16'(16'h2000 + i)};
            @(negedge clk);
        end
        wr = 1'b0;
        wait_idle(1000);
        check("t5_cnt",  q_a.size(), 10);
        for (int i = 0; i < 5; i++) begin
            check("t5_lo", qa(2*i),   {28'(28'h100 + 4*i), 16'(16'h2000 + i)});
            check("t5_hi", qa(2*i+1), {28'(28'h102 + 4*i), 16'(16'h1000 + i)});
        end
        check("t5_cnt_b", q_b.size(), 20);
        check("t5_ovf_a", a_ovf, 1);
        check("t5_ovf_b", b_ovf, 1);
        repeat (5) @(negedge clk);
        check("t5_sticky", a_ovf, 1);
        do_reset();
        check("t5_ovf_clr", a_ovf, 0);

        // Asynchronous reset in the middle of a WAIT
        clear_q();
        do_wr(32'h0000_0200, 32'hCAFE_F00D, 1'b1);
        n = 0;
        while (q_a.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_pulse", q_a.size(), 1);
        check("t6_first", qa(0), {28'h200, 16'hF00D});
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t6_addr", a_addr, 0);
        check("t6_data", a_data, 0);
        check("t6_busy", a_busy, 0);
        check("t6_en",   a_en,   0);
        check("t6_b_addr", b_addr, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_no_more_a", q_a.size(), 1);
        check("t6_no_more_b", q_b.size(), 1);
        check("t6_idle", a_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
